decrypt_round_sequencer: RTL and testbench

DECRYPT_ROUND_SEQUENCER -- requirements
Module: decrypt_round_sequencer

---
 rtl/decrypt_round_sequencer.sv | 148 ++++++++++++++
 tb/tb_decrypt_round_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_round_sequencer.sv
// Iterative block-decryption sequencer: drives an external single-round stage NUM_ROUNDS times per block,
// applying round keys in reverse order. Optional block counter enabled by defining BLOCK_COUNT_EN.
module decrypt_round_sequencer #(
  parameter int NUM_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_wr,
  input  logic [3:0]  key_addr,
  input  logic [15:0] key_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_d0,
  input  logic [15:0] in_d1,
  input  logic [15:0] in_d2,
  input  logic [15:0] in_d3,
  output logic [15:0] st_d0,
  output logic [15:0] st_d1,
  output logic [15:0] st_d2,
  output logic [15:0] st_d3,
  output logic        st_wr,
  output logic [15:0] st_key,
  input  logic [15:0] st_q0,
  input  logic [15:0] st_q1,
  input  logic [15:0] st_q2,
  input  logic [15:0] st_q3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_d0,
  output logic [15:0] out_d1,
  output logic [15:0] out_d2,
  output logic [15:0] out_d3
`ifdef BLOCK_COUNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  localparam int DATA_W = 16;
  localparam int RND_W  = $clog2(NUM_ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [RND_W-1:0]   rnd;
  logic [DATA_W-1:0]  key_reg [NUM_ROUNDS];
  logic [DATA_W-1:0]  work0, work1, work2, work3;
  logic [DATA_W-1:0]  key_sel;
  logic               load, capture, last_rnd;

  assign last_rnd = (rnd == RND_W'(NUM_ROUNDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    st_wr     = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        st_wr     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        capture   = 1'b1;
        state_nxt = last_rnd ? DONE : ISSUE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Work registers, round counter and key file; all cleared by reset so an aborted block leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd   <= '0;
      work0 <= '0;
      work1 <= '0;
      work2 <= '0;
      work3 <= '0;
      for (int i = 0; i < NUM_ROUNDS; i++) key_reg[i] <= '0;
    end else begin
      if (load) begin
        work0 <= in_d0;
        work1 <= in_d1;
        work2 <= in_d2;
        work3 <= in_d3;
        rnd   <= '0;
      end
      if (capture) begin
        work0 <= st_q0;
        work1 <= st_q1;
        work2 <= st_q2;
        work3 <= st_q3;
        rnd   <= last_rnd ? '0 : rnd + 1'b1;
      end
      // Out-of-range addresses match no entry and are dropped.
      if (key_wr && state == IDLE) begin
        for (int i = 0; i < NUM_ROUNDS; i++)
          if (key_addr == 4'(i)) key_reg[i] <= key_data;
      end
    end
  end

  always_comb begin
    key_sel = '0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (NUM_ROUNDS - 1 - i == int'(rnd)) key_sel = key_reg[i];
  end

  assign st_key = st_wr ? key_sel : '0;
  assign st_d0  = st_wr ? work0 : '0;
  assign st_d1  = st_wr ? work1 : '0;
  assign st_d2  = st_wr ? work2 : '0;
  assign st_d3  = st_wr ? work3 : '0;

  assign out_d0 = out_valid ? work0 : '0;
  assign out_d1 = out_valid ? work1 : '0;
  assign out_d2 = out_valid ? work2 : '0;
  assign out_d3 = out_valid ? work3 : '0;

`ifdef BLOCK_COUNT_EN
  logic blk_done;
  assign blk_done = (state == DONE) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              blk_cnt <= '0;
    else if (blk_done && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decrypt_round_sequencer.sv
// Scoreboard bench for decrypt_round_sequencer with an XOR-key single-round stage stub.
// Define BLOCK_COUNT_EN to also exercise the block counter.
module tb_decrypt_round_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_wr = 1'b0;
  logic [3:0]  key_addr = '0;
  logic [15:0] key_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic [15:0] st_d0, st_d1, st_d2, st_d3;
  logic        st_wr;
  logic [15:0] st_key;
  logic [15:0] st_q0 = '0, st_q1 = '0, st_q2 = '0, st_q3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_d0, out_d1, out_d2, out_d3;
`ifdef BLOCK_COUNT_EN
  logic [15:0] blk_cnt;
`endif

  decrypt_round_sequencer #(.NUM_ROUNDS(8)) dut (
    .clk(clk), .reset(reset),
    .key_wr(key_wr), .key_addr(key_addr), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .st_d0(st_d0), .st_d1(st_d1), .st_d2(st_d2), .st_d3(st_d3),
    .st_wr(st_wr), .st_key(st_key),
    .st_q0(st_q0), .st_q1(st_q1), .st_q2(st_q2), .st_q3(st_q3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3)
`ifdef BLOCK_COUNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stage stub: q0 = d0 ^ key, q1..q3 pass through, one cycle latency.
  always @(posedge clk) begin
    if (st_wr) begin
      st_q0 <= st_d0 ^ st_key;
      st_q1 <= st_d1;
      st_q2 <= st_d2;
      st_q3 <= st_d3;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        ov_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [15:0] key_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares outputs at the falling edge, ahead of the edge where the handshake completes.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_prev) chk("latency", 80'(cyc - acc_cyc), 80'd16);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: actual=%h required=no output", {out_d0, out_d1, out_d2, out_d3});
        end else begin
          chk("out_d", 80'({out_d0, out_d1, out_d2, out_d3}), 80'(exp_q.pop_front()));
        end
      end
      if (st_wr) begin
        if (key_q.size() > 0) chk("st_key_order", 80'(st_key), 80'(key_q.pop_front()));
      end else begin
        chk("st_gate", {st_key, st_d0, st_d1, st_d2, st_d3}, 80'd0);
      end
    end
    ov_prev = out_valid;
  end

  task automatic send_block(input logic [15:0] a, b, c, d, input logic [63:0] req, input bit push);
    int n;
    n = 0;
    in_d0 = a; in_d1 = b; in_d2 = c; in_d3 = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
    end else begin
      if (push) exp_q.push_back(req);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [15:0] d);
    key_addr = a;
    key_data = d;
    key_wr   = 1'b1;
    @(posedge clk);
    #1 key_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_stage", 80'({st_wr, st_key, st_d0, st_d1, st_d2, st_d3}), 80'd0);
    chk("rst_out_d", 80'({out_d0, out_d1, out_d2, out_d3}), 80'd0);
`ifdef BLOCK_COUNT_EN
    chk("rst_blk_cnt", 80'(blk_cnt), 80'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("post_rst_in_ready", 80'(in_ready), 80'd1);
    chk("post_rst_out_valid", 80'(out_valid), 80'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    do_reset();

    // Keys 1..8, applied 8 down to 1; XOR of all keys is 0x0008.
    for (int i = 0; i < 8; i++) write_key(4'(i), 16'(i + 1));
    for (int i = 0; i < 8; i++) key_q.push_back(16'(8 - i));
    send_block(16'h1234, 16'hAAAA, 16'h5555, 16'h0F0F, 64'h123C_AAAA_5555_0F0F, 1'b1);
    wait_drain();
    chk("key_seq_done", 80'(key_q.size()), 80'd0);

    // Only the last key set: it must be the first applied.
    do_reset();
    write_key(4'd7, 16'h8000);
    key_q.push_back(16'h8000);
    for (int i = 0; i < 7; i++) key_q.push_back(16'h0000);
    send_block(16'h0000, 16'h0001, 16'h0002, 16'h0003, 64'h8000_0001_0002_0003, 1'b1);
    wait_drain();
    chk("key_seq2_done", 80'(key_q.size()), 80'd0);

    // Backpressure in DONE with a pending input block.
    out_ready = 1'b0;
    send_block(16'h0001, 16'h00F0, 16'h0F00, 16'hF000, 64'h8001_00F0_0F00_F000, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 80'(out_valid), 80'd1);
    @(posedge clk);
    #1;
    in_d0 = 16'h4321; in_d1 = 16'h0001; in_d2 = 16'h0002; in_d3 = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_d", 80'({out_d0, out_d1, out_d2, out_d3}), 80'h8001_00F0_0F00_F000);
      chk("bp_in_ready", 80'(in_ready), 80'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_block(16'h4321, 16'h0001, 16'h0002, 16'h0003, 64'hC321_0001_0002_0003, 1'b1);
    wait_drain();

    // Reset in the third WAIT discards the block.
    do_reset();
    send_block(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 64'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("third_wait_st_wr", 80'(st_wr), 80'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 80'(in_ready), 80'd1);
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    send_block(16'h1111, 16'h2222, 16'h3333, 16'h4444, 64'h1111_2222_3333_4444, 1'b1);
    wait_drain();

    // Out-of-range key address in IDLE and any key write outside IDLE are ignored.
    write_key(4'd9, 16'h7777);
    send_block(16'h5A5A, 16'h0001, 16'h0002, 16'h0003, 64'h5A5A_0001_0002_0003, 1'b1);
    write_key(4'd2, 16'hFFFF);
    wait_drain();
    send_block(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 64'h0000_FFFF_0000_FFFF, 1'b1);
    wait_drain();

`ifdef BLOCK_COUNT_EN
    do_reset();
    send_block(16'h0001, 16'h0002, 16'h0003, 16'h0004, 64'h0001_0002_0003_0004, 1'b1);
    send_block(16'h0005, 16'h0006, 16'h0007, 16'h0008, 64'h0005_0006_0007_0008, 1'b1);
    send_block(16'h0009, 16'h000A, 16'h000B, 16'h000C, 64'h0009_000A_000B_000C, 1'b1);
    wait_drain();
    chk("blk_cnt_three", 80'(blk_cnt), 80'd3);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
